itrx_aib_phy_tx_ser: RTL

Transmit-side DDR serializer for the AIB PHY data path, the launching end of the latch-based receive capture. It accepts parallel words from the adapter through a valid/ready handshake, buffers them in a small FIFO, and emits two bits per clock on even/odd lanes for the downstream DDR output mux. The even lane is launched on the rising half and the odd lane on the falling half. The far-end receiver latches reconstruct the word.

---
 rtl/itrx_aib_phy_tx_ser_pkg.sv | 18 +
 rtl/itrx_aib_phy_tx_fifo.sv | 58 +++++
 rtl/itrx_aib_phy_tx_ser.sv | 107 ++++++++++
 3 files changed

// File: rtl/itrx_aib_phy_tx_ser_pkg.sv
// Shared definitions for the AIB PHY transmit serializer: state encoding,
// default geometry and the pair-counter width helper.
package itrx_aib_phy_tx_ser_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Pair counter needs at least one bit even when a word is a single pair.
  function automatic int pair_cnt_w(input int dwidth);
    return ((dwidth / 2) > 1) ? $clog2(dwidth / 2) : 1;
  endfunction

endpackage

// File: rtl/itrx_aib_phy_tx_fifo.sv
// Synchronous word FIFO with wrapping pointers; callers guarantee that a
// push never hits a full FIFO and a pop never hits an empty one.
module itrx_aib_phy_tx_fifo
  import itrx_aib_phy_tx_ser_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_r <= '0;
      rptr_r <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == LW'(0));

endmodule

// File: rtl/itrx_aib_phy_tx_ser.sv
// AIB PHY transmit DDR serializer: buffers adapter words and emits one
// even/odd bit pair per clock, LSB pair first.
module itrx_aib_phy_tx_ser
  import itrx_aib_phy_tx_ser_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              tx_en,
  output logic              tx_even,
  output logic              tx_odd,
  output logic              tx_vld,
  output logic              tx_sow,
  output logic [LW-1:0]     fifo_level
);

  localparam int              KW     = pair_cnt_w(DWIDTH);
  localparam logic [KW-1:0]   K_LAST = KW'(DWIDTH / 2 - 1);

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              at_bound_s;
  logic [DWIDTH-1:0] rdata_s;

  tx_state_e         state_r;
  logic [KW-1:0]     k_r;
  logic [DWIDTH-1:0] sreg_r;

  assign in_ready   = rstn & ~full_s;
  assign push_s     = in_valid & in_ready;
  // A new word may only be taken while idle or while the last pair is out.
  assign at_bound_s = (state_r == ST_IDLE) | (k_r == K_LAST);
  assign pop_s      = rstn & tx_en & ~empty_s & at_bound_s;

  itrx_aib_phy_tx_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // Serializer FSM; k_r names the pair currently presented on the outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      sreg_r  <= '0;
      tx_even <= 1'b0;
      tx_odd  <= 1'b0;
      tx_vld  <= 1'b0;
      tx_sow  <= 1'b0;
    end else if (pop_s) begin
      state_r <= ST_SHIFT;
      k_r     <= '0;
      sreg_r  <= rdata_s >> 2;
      tx_even <= rdata_s[0];
      tx_odd  <= rdata_s[1];
      tx_vld  <= 1'b1;
      tx_sow  <= 1'b1;
    end else begin
      case (state_r)
        ST_SHIFT: begin
          if (k_r == K_LAST) begin
            state_r <= ST_IDLE;
            k_r     <= '0;
            tx_even <= 1'b0;
            tx_odd  <= 1'b0;
            tx_vld  <= 1'b0;
            tx_sow  <= 1'b0;
          end else begin
            k_r     <= k_r + KW'(1);
            sreg_r  <= sreg_r >> 2;
            tx_even <= sreg_r[0];
            tx_odd  <= sreg_r[1];
            tx_vld  <= 1'b1;
            tx_sow  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          k_r     <= '0;
          tx_even <= 1'b0;
          tx_odd  <= 1'b0;
          tx_vld  <= 1'b0;
          tx_sow  <= 1'b0;
        end
      endcase
    end
  end

endmodule
